// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - two-pixel-beat FIFO feeding a one-pixel-per-cycle valid/ready stream
// Optional feature macro: PIX_CHECKSUM_EN (adds CHECKSUM output with per-frame R+G+B sum)
module pixel_serializer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 426,
  parameter int DEPTH  = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSYNC,
  input  logic [7:0]  DATA_R0,
  input  logic [7:0]  DATA_G0,
  input  logic [7:0]  DATA_B0,
  input  logic [7:0]  DATA_R1,
  input  logic [7:0]  DATA_G1,
  input  logic [7:0]  DATA_B1,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic [7:0]  PIX_R,
  output logic [7:0]  PIX_G,
  output logic [7:0]  PIX_B,
  output logic        PIX_EOL,
  output logic        PIX_EOF,
  output logic        OVERFLOW
`ifdef PIX_CHECKSUM_EN
  ,
  output logic [15:0] CHECKSUM
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_EMPTY, S_P0, S_P1} state_t;

  state_t      state_q;
  logic [AW:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [47:0] mem_q [DEPTH];
  logic [47:0] head_beat, next_beat;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic        valid_q, eol_q, eof_q, overflow_q;
  logic [23:0] pix_q;
  logic        eol_d, eof_d;
  logic        empty, full, xfer, pop, push, more;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign xfer    = valid_q && PIX_READY;
  assign pop     = xfer && (state_q == S_P1);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the beat.
  assign push    = HSYNC && (!full || pop);
  assign rd_next = rd_ptr_q + 1'b1;
  assign more    = (rd_next != wr_ptr_q);

  assign head_beat = mem_q[rd_ptr_q[AW-1:0]];
  assign next_beat = mem_q[rd_next[AW-1:0]];

  // Position of the pixel that will be presented after this cycle, and its line/frame flags.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    eol_d = (col_d == COL_LAST);
    eof_d = eol_d && (row_d == ROW_LAST);
  end

  // Beat storage; contents need no reset because the pointers define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0};
  end

  // FIFO pointers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_next;
    end
  end

  // Sticky drop flag: a beat arrived with no room and no simultaneous pop.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                       overflow_q <= 1'b0;
    else if (HSYNC && full && !pop)     overflow_q <= 1'b1;
  end

  // Output column/row counters advance once per accepted pixel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Output FSM: walks the even then odd pixel of the head beat with registered outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      pix_q   <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (!empty) begin
            state_q <= S_P0;
            valid_q <= 1'b1;
            pix_q   <= head_beat[23:0];
            eol_q   <= eol_d;
            eof_q   <= eof_d;
          end
        end
        S_P0: begin
          if (xfer) begin
            state_q <= S_P1;
            pix_q   <= head_beat[47:24];
            eol_q   <= eol_d;
            eof_q   <= eof_d;
          end
        end
        S_P1: begin
          if (xfer) begin
            if (more) begin
              state_q <= S_P0;
              pix_q   <= next_beat[23:0];
              eol_q   <= eol_d;
              eof_q   <= eof_d;
            end else begin
              state_q <= S_EMPTY;
              valid_q <= 1'b0;
              pix_q   <= '0;
              eol_q   <= 1'b0;
              eof_q   <= 1'b0;
            end
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign PIX_VALID = valid_q;
  assign PIX_R     = pix_q[23:16];
  assign PIX_G     = pix_q[15:8];
  assign PIX_B     = pix_q[7:0];
  assign PIX_EOL   = eol_q;
  assign PIX_EOF   = eof_q;
  assign OVERFLOW  = overflow_q;

`ifdef PIX_CHECKSUM_EN
  logic [15:0] acc_q, checksum_q, acc_sum;
  assign acc_sum = acc_q + 16'(pix_q[23:16]) + 16'(pix_q[15:8]) + 16'(pix_q[7:0]);

  // Accumulate every accepted pixel; latch the total and restart on the frame's last pixel.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else if (xfer) begin
      if (eof_q) begin
        checksum_q <= acc_sum;
        acc_q      <= '0;
      end else begin
        acc_q      <= acc_sum;
      end
    end
  end

  assign CHECKSUM = checksum_q;
`endif

endmodule

// File: tb/tb_pixel_serializer.sv
// tb/tb_pixel_serializer.sv - directed self-checking bench for pixel_serializer (8x2 frame, depth 16)
module tb_pixel_serializer;

  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hsync = 1'b0;
  logic [7:0] r0 = '0, g0 = '0, b0 = '0, r1 = '0, g1 = '0, b1 = '0;
  logic pix_ready = 1'b0;
  logic pix_valid, pix_eol, pix_eof, overflow;
  logic [7:0] pix_r, pix_g, pix_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

`ifdef PIX_CHECKSUM_EN
  logic [15:0] checksum;
  logic pv4, pe4l, pe4f, ov4;
  logic [7:0] pr4, pg4, pb4;
  logic [15:0] checksum4;
`endif

  pixel_serializer #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) u_dut (
    .HCLK(clk), .HRESETn(rst_n), .HSYNC(hsync),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
    .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .PIX_VALID(pix_valid), .PIX_READY(pix_ready),
    .PIX_R(pix_r), .PIX_G(pix_g), .PIX_B(pix_b),
    .PIX_EOL(pix_eol), .PIX_EOF(pix_eof), .OVERFLOW(overflow)
`ifdef PIX_CHECKSUM_EN
    , .CHECKSUM(checksum)
`endif
  );

`ifdef PIX_CHECKSUM_EN
  pixel_serializer #(.WIDTH(4), .HEIGHT(1), .DEPTH(D)) u_dut4 (
    .HCLK(clk), .HRESETn(rst_n), .HSYNC(hsync),
    .DATA_R0(r0), .DATA_G0(g0), .DATA_B0(b0),
    .DATA_R1(r1), .DATA_G1(g1), .DATA_B1(b1),
    .PIX_VALID(pv4), .PIX_READY(pix_ready),
    .PIX_R(pr4), .PIX_G(pg4), .PIX_B(pb4),
    .PIX_EOL(pe4l), .PIX_EOF(pe4f), .OVERFLOW(ov4),
    .CHECKSUM(checksum4)
  );
`endif

  function automatic logic [23:0] exp_px(input int p);
    return {8'(p), 8'(p + 32), 8'(p + 64)};
  endfunction

  task automatic drive_beat(input int p);
    hsync = 1'b1;
    r0 = 8'(p);     g0 = 8'(p + 32); b0 = 8'(p + 64);
    r1 = 8'(p + 1); g1 = 8'(p + 33); b1 = 8'(p + 65);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hsync = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hsync = 1'b0; pix_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({pix_valid, pix_eol, pix_eof, overflow} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000", {pix_valid, pix_eol, pix_eof, overflow});
    end
    tests_run++;
    if ({pix_r, pix_g, pix_b} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_pixel: got %h expected 000000", {pix_r, pix_g, pix_b});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    do_reset();
    pix_ready = 1'b1;
    hsync = 1'b1;
    r0 = 8'd1; g0 = 8'd2; b0 = 8'd3; r1 = 8'd4; g1 = 8'd5; b1 = 8'd6;
    @(negedge clk);
    hsync = 1'b0;
    tests_run++;
    if (pix_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency1: valid got %b expected 0", pix_valid);
    end
    @(negedge clk);
    tests_run++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_eol} !== {1'b1, 24'h010203, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_px0: got %h expected %h", {pix_valid, pix_r, pix_g, pix_b, pix_eol}, {1'b1, 24'h010203, 1'b0});
    end
    @(negedge clk);
    tests_run++;
    if ({pix_valid, pix_r, pix_g, pix_b} !== {1'b1, 24'h040506}) begin
      tests_failed++;
      $display("FAIL single_px1: got %h expected %h", {pix_valid, pix_r, pix_g, pix_b}, {1'b1, 24'h040506});
    end
    @(negedge clk);
    tests_run++;
    if (pix_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_drain: valid got %b expected 0", pix_valid);
    end
  endtask

  task automatic test_overflow();
    int got;
    do_reset();
    pix_ready = 1'b0;
    for (int b = 0; b < 17; b++) begin
      drive_beat(2 * b);
      @(negedge clk);
      if (b == 15) begin
        tests_run++;
        if (overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_at_16: got %b expected 0", overflow);
        end
      end
    end
    hsync = 1'b0;
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_at_17: got %b expected 1", overflow);
    end
    tests_run++;
    if ({pix_valid, pix_r, pix_g, pix_b} !== {1'b1, exp_px(0)}) begin
      tests_failed++;
      $display("FAIL ovf_hold: got %h expected %h", {pix_valid, pix_r, pix_g, pix_b}, {1'b1, exp_px(0)});
    end
    pix_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 32; cyc++) begin
      if (pix_valid) begin
        tests_run++;
        if ({pix_r, pix_g, pix_b} !== exp_px(got)) begin
          tests_failed++;
          $display("FAIL ovf_drain[%0d]: got %h expected %h", got, {pix_r, pix_g, pix_b}, exp_px(got));
        end
        got++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (got != 32) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d expected 32", got);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({pix_valid, overflow} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_after_drain: got %b expected 01", {pix_valid, overflow});
    end
  endtask

  task automatic test_frame();
    int got;
    do_reset();
    pix_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      if (cyc < 8) drive_beat(2 * cyc); else hsync = 1'b0;
      if (pix_valid) begin
        tests_run++;
        if ({pix_r, pix_g, pix_b, pix_eol, pix_eof} !== {exp_px(got), (got == 7 || got == 15), (got == 15)}) begin
          tests_failed++;
          $display("FAIL frame[%0d]: got %h expected %h", got, {pix_r, pix_g, pix_b, pix_eol, pix_eof},
                   {exp_px(got), (got == 7 || got == 15), (got == 15)});
        end
        got++;
      end
      @(negedge clk);
    end
    hsync = 1'b0;
    tests_run++;
    if (got != 16) begin
      tests_failed++;
      $display("FAIL frame_count: got %0d expected 16", got);
    end
  endtask

  task automatic test_random_stall();
    int got;
    logic stalled;
    logic [25:0] snap;
    do_reset();
    got = 0;
    stalled = 1'b0;
    snap = '0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      if (cyc < 8) drive_beat(2 * cyc); else hsync = 1'b0;
      if (stalled) begin
        tests_run++;
        if ({pix_valid, pix_r, pix_g, pix_b, pix_eol, pix_eof} !== {1'b1, snap}) begin
          tests_failed++;
          $display("FAIL stall_hold[%0d]: got %h expected %h", got, {pix_valid, pix_r, pix_g, pix_b, pix_eol, pix_eof}, {1'b1, snap});
        end
      end
      pix_ready = 1'($urandom_range(0, 1));
      if (pix_valid && pix_ready) begin
        tests_run++;
        if ({pix_r, pix_g, pix_b, pix_eol, pix_eof} !== {exp_px(got), (got == 7 || got == 15), (got == 15)}) begin
          tests_failed++;
          $display("FAIL stall_px[%0d]: got %h expected %h", got, {pix_r, pix_g, pix_b, pix_eol, pix_eof},
                   {exp_px(got), (got == 7 || got == 15), (got == 15)});
        end
        got++;
        stalled = 1'b0;
      end else if (pix_valid) begin
        stalled = 1'b1;
        snap = {pix_r, pix_g, pix_b, pix_eol, pix_eof};
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    hsync = 1'b0;
    tests_run++;
    if (got != 16) begin
      tests_failed++;
      $display("FAIL stall_count: got %0d expected 16", got);
    end
  endtask

  task automatic test_reset_midline();
    int got;
    do_reset();
    pix_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      if (cyc < 2) drive_beat(100 + 2 * cyc); else hsync = 1'b0;
      if (pix_valid) got++;
      @(negedge clk);
    end
    hsync = 1'b0;
    tests_run++;
    if (got != 3 || pix_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midline_setup: got %0d pixels valid %b expected 3 and 1", got, pix_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pix_valid, pix_r, pix_g, pix_b, pix_eol, pix_eof, overflow} !== 28'h0) begin
      tests_failed++;
      $display("FAIL midline_async: got %h expected 0", {pix_valid, pix_r, pix_g, pix_b, pix_eol, pix_eof, overflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (cyc < 4) drive_beat(2 * cyc); else hsync = 1'b0;
      if (pix_valid) begin
        tests_run++;
        if ({pix_r, pix_g, pix_b, pix_eol} !== {exp_px(got), (got == 7)}) begin
          tests_failed++;
          $display("FAIL midline_restart[%0d]: got %h expected %h", got, {pix_r, pix_g, pix_b, pix_eol}, {exp_px(got), (got == 7)});
        end
        got++;
      end
      @(negedge clk);
    end
    hsync = 1'b0;
    tests_run++;
    if (got != 8) begin
      tests_failed++;
      $display("FAIL midline_count: got %0d expected 8", got);
    end
  endtask

`ifdef PIX_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    pix_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      hsync = 1'b1;
      r0 = 8'd10; g0 = 8'd20; b0 = 8'd30; r1 = 8'd10; g1 = 8'd20; b1 = 8'd30;
      @(negedge clk);
    end
    hsync = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (checksum4 !== 16'd240) begin
      tests_failed++;
      $display("FAIL checksum_4x1: got %0d expected 240", checksum4);
    end
    tests_run++;
    if (checksum !== 16'd0) begin
      tests_failed++;
      $display("FAIL checksum_partial: got %0d expected 0", checksum);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_beat();
    test_overflow();
    test_frame();
    test_random_stall();
    test_reset_midline();
`ifdef PIX_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
